// File: rtl/seg_scan_ctrl_pkg.sv
// seg_pkg: shared constants and types for the seven-segment scan controller.
//   SEG_0..SEG_F : 7-bit segment patterns, bit order abc_defg (bit 6 = a), 1 = lit.
//   SEG_BLANK    : all segments off.
//   scan_state_t : scan FSM states (BLANK gap, SHOW digit).
package seg_pkg;

   localparam logic [6:0] SEG_0     = 7'b111_1110;
   localparam logic [6:0] SEG_1     = 7'b011_0000;
   localparam logic [6:0] SEG_2     = 7'b110_1101;
   localparam logic [6:0] SEG_3     = 7'b111_1001;
   localparam logic [6:0] SEG_4     = 7'b011_0011;
   localparam logic [6:0] SEG_5     = 7'b101_1011;
   localparam logic [6:0] SEG_6     = 7'b101_1111;
   localparam logic [6:0] SEG_7     = 7'b111_0000;
   localparam logic [6:0] SEG_8     = 7'b111_1111;
   localparam logic [6:0] SEG_9     = 7'b111_1011;
   localparam logic [6:0] SEG_A     = 7'b111_0111;
   localparam logic [6:0] SEG_B     = 7'b001_1111;
   localparam logic [6:0] SEG_C     = 7'b100_1110;
   localparam logic [6:0] SEG_D     = 7'b011_1101;
   localparam logic [6:0] SEG_E     = 7'b100_1111;
   localparam logic [6:0] SEG_F     = 7'b100_0111;
   localparam logic [6:0] SEG_BLANK = 7'b000_0000;

   typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} scan_state_t;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: load handshake between the numeric datapath and the scan controller.
//   load_valid : source offers a digit vector
//   load_ready : controller can take a vector
//   digits_in  : nibble i = digit i, digit 0 least significant
// Modports: master = data source, slave = controller.
interface seg_scan_ctrl_if #(
   parameter int N_DIGITS = 4
);
   logic                    load_valid;
   logic                    load_ready;
   logic [4*N_DIGITS-1:0]   digits_in;

   modport master (output load_valid, output digits_in, input load_ready);
   modport slave  (input load_valid, input digits_in, output load_ready);
endinterface

// File: rtl/seg_scan_ctrl_decode.sv
// seg_decode: combinational hex-to-seven-segment decoder.
//   hex_i : 4-bit value 0..F
//   seg_o : segments abc_defg (bit 6 = a), 1 = lit
module seg_decode
   import seg_pkg::*;
(
   input  logic [3:0] hex_i,
   output logic [6:0] seg_o
);
   always_comb begin
      seg_o = SEG_BLANK;
      case (hex_i)
         4'h0: seg_o = SEG_0;
         4'h1: seg_o = SEG_1;
         4'h2: seg_o = SEG_2;
         4'h3: seg_o = SEG_3;
         4'h4: seg_o = SEG_4;
         4'h5: seg_o = SEG_5;
         4'h6: seg_o = SEG_6;
         4'h7: seg_o = SEG_7;
         4'h8: seg_o = SEG_8;
         4'h9: seg_o = SEG_9;
         4'hA: seg_o = SEG_A;
         4'hB: seg_o = SEG_B;
         4'hC: seg_o = SEG_C;
         4'hD: seg_o = SEG_D;
         4'hE: seg_o = SEG_E;
         4'hF: seg_o = SEG_F;
         default: seg_o = SEG_BLANK;
      endcase
   end
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for an N-digit seven-segment display.
// Each digit slot is a BLANK gap of BLANK_TICKS ticks followed by SHOW_TICKS ticks lit;
// one tick every PRESCALE clocks. New vectors are latched into a shadow register via
// the handshake and copied to the displayed (active) register only at frame end.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   ld         : seg_scan_ctrl_if.slave (load_valid / load_ready / digits_in)
//   seg        : segments abc_defg, 1 = lit (registered)
//   an         : one-hot digit enable, all-zero while blank (registered)
//   frame_done : one-cycle pulse at the end of each full scan
// Optional: define LEADING_ZERO_BLANK_EN to suppress leading zero digits (digit 0 always shown).
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int N_DIGITS    = 4,
   parameter int PRESCALE    = 1000,
   parameter int BLANK_TICKS = 1,
   parameter int SHOW_TICKS  = 8
) (
   input  logic                clk,
   input  logic                reset,
   seg_scan_ctrl_if.slave      ld,
   output logic [6:0]          seg,
   output logic [N_DIGITS-1:0] an,
   output logic                frame_done
);
   localparam int PC_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int TMAX  = (BLANK_TICKS > SHOW_TICKS) ? BLANK_TICKS : SHOW_TICKS;
   localparam int TC_W  = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int DW    = 4 * N_DIGITS;

   logic [PC_W-1:0]     pc_q;
   logic [TC_W-1:0]     tc_q;
   logic [TC_W-1:0]     tc_lim;
   logic [IDX_W-1:0]    idx_q;
   scan_state_t         state_q;
   logic [DW-1:0]       active_q;
   logic [DW-1:0]       shadow_q;
   logic                pending_q;
   logic [6:0]          seg_q;
   logic [N_DIGITS-1:0] an_q;
   logic                frame_done_q;
   logic                tick;
   logic                last_digit;
   logic                lz_blank;
   logic [3:0]          cur_hex;
   logic [6:0]          dec_seg;

   assign tick       = (pc_q == PC_W'(PRESCALE - 1));
   assign tc_lim     = (state_q == BLANK) ? TC_W'(BLANK_TICKS - 1) : TC_W'(SHOW_TICKS - 1);
   assign last_digit = (idx_q == IDX_W'(N_DIGITS - 1));
   assign cur_hex    = active_q[{idx_q, 2'b00} +: 4];

   assign ld.load_ready = !pending_q;
   assign seg           = seg_q;
   assign an            = an_q;
   assign frame_done    = frame_done_q;

   seg_decode u_dec (
      .hex_i (cur_hex),
      .seg_o (dec_seg)
   );

`ifdef LEADING_ZERO_BLANK_EN
   // Blank the current digit if it and every more significant digit are zero.
   always_comb begin
      lz_blank = (idx_q != '0);
      for (int i = 0; i < N_DIGITS; i++) begin
         if (i >= int'(idx_q) && active_q[4*i +: 4] != 4'h0) lz_blank = 1'b0;
      end
   end
`else
   assign lz_blank = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) pc_q <= '0;
      else if (tick) pc_q <= '0;
      else pc_q <= pc_q + 1'b1;
   end

   // Scan FSM, handshake and frame-boundary commit. Outputs change on the
   // same edge that enters the new state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= BLANK;
         tc_q         <= '0;
         idx_q        <= '0;
         seg_q        <= SEG_BLANK;
         an_q         <= '0;
         frame_done_q <= 1'b0;
         active_q     <= '0;
         shadow_q     <= '0;
         pending_q    <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         if (ld.load_valid && !pending_q) begin
            shadow_q  <= ld.digits_in;
            pending_q <= 1'b1;
         end
         if (tick) begin
            if (tc_q == tc_lim) begin
               tc_q <= '0;
               if (state_q == BLANK) begin
                  state_q <= SHOW;
                  if (lz_blank) begin
                     an_q  <= '0;
                     seg_q <= SEG_BLANK;
                  end else begin
                     an_q  <= N_DIGITS'(1) << idx_q;
                     seg_q <= dec_seg;
                  end
               end else begin
                  state_q <= BLANK;
                  an_q    <= '0;
                  seg_q   <= SEG_BLANK;
                  if (last_digit) begin
                     idx_q        <= '0;
                     frame_done_q <= 1'b1;
                     // pending blocks new offers, so shadow is stable here
                     if (pending_q) begin
                        active_q  <= shadow_q;
                        pending_q <= 1'b0;
                     end
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end else begin
               tc_q <= tc_q + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;
   localparam int N     = 4;
   localparam int P     = 2;
   localparam int B     = 1;
   localparam int S     = 2;
   localparam int L     = (B + S) * P;
   localparam int FRAME = N * L;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] seg;
   logic [3:0] an;
   logic       frame_done;

   seg_scan_ctrl_if #(.N_DIGITS(N)) ld ();

   seg_scan_ctrl #(.N_DIGITS(N), .PRESCALE(P), .BLANK_TICKS(B), .SHOW_TICKS(S)) dut (
      .clk        (clk),
      .reset      (reset),
      .ld         (ld),
      .seg        (seg),
      .an         (an),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: k = clock edges since reset release.
   int          k;
   logic [15:0] m_active, m_shadow;
   bit          m_pending;

   logic [6:0] segtab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                               7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                               7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                               7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

   function automatic bit lzb(int d);
`ifdef LEADING_ZERO_BLANK_EN
      return (d != 0) && ((m_active >> (4 * d)) == 16'h0);
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit showing();
      return (k % L) >= B * P;
   endfunction

   function automatic logic [12:0] expected();
      int d;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      d = (k / L) % N;
      e_an = 4'h0;
      e_seg = 7'h0;
      if (showing() && !lzb(d)) begin
         e_an  = 4'(1 << d);
         e_seg = segtab[m_active[4*d +: 4]];
      end
      return {(k > 0 && k % FRAME == 0), !m_pending, e_an, e_seg};
   endfunction

   // Advance one clock edge, applying the handshake and frame-end commit rules.
   task automatic step();
      logic lv;
      logic [15:0] din;
      bit old;
      @(posedge clk);
      lv = ld.load_valid;
      din = ld.digits_in;
      old = m_pending;
      k++;
      if (lv && !old) begin
         m_shadow = din;
         m_pending = 1'b1;
      end
      if (k % FRAME == 0 && old) begin
         m_active = m_shadow;
         m_pending = 1'b0;
      end
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      ld.load_valid = 1'b0;
      ld.digits_in = 16'h0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      k = 0;
      m_active = 16'h0;
      m_shadow = 16'h0;
      m_pending = 1'b0;
   endtask

   task automatic test_reset();
      int first_fd;
      reset = 1'b1;
      ld.load_valid = 1'b0;
      ld.digits_in = 16'h0;
      #1;
      checks++;
      if ({frame_done, ld.load_ready, an, seg} !== 13'b0_1_0000_0000000) begin
         $display("FAIL reset_values got=%b want=%b", {frame_done, ld.load_ready, an, seg}, 13'b0_1_0000_0000000);
         errors++;
      end
      do_reset();
      first_fd = -1;
      for (int c = 0; c < FRAME + 8; c++) begin
         step();
         checks++;
         if ({frame_done, ld.load_ready, an, seg} !== expected()) begin
            $display("FAIL reset_scan k=%0d got=%b want=%b", k, {frame_done, ld.load_ready, an, seg}, expected());
            errors++;
         end
         if (frame_done === 1'b1 && first_fd < 0) first_fd = k;
         if (k == 2) begin
            checks++;
            if (an !== 4'b0001 || seg !== 7'b1111110) begin
               $display("FAIL first_digit an=%b seg=%b want an=0001 seg=1111110", an, seg);
               errors++;
            end
         end
      end
      checks++;
      if (first_fd != FRAME) begin
         $display("FAIL first_frame_done got=%0d want=%0d", first_fd, FRAME);
         errors++;
      end
   endtask

   task automatic test_load();
      logic [6:0] want [4] = '{7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000};
      do_reset();
      for (int c = 0; c < 2 * FRAME + 2; c++) begin
         ld.load_valid = (k == 2);
         ld.digits_in = 16'h1234;
         step();
         checks++;
         if ({frame_done, ld.load_ready, an, seg} !== expected()) begin
            $display("FAIL load_scan k=%0d got=%b want=%b", k, {frame_done, ld.load_ready, an, seg}, expected());
            errors++;
         end
         if (k == 10) begin
            checks++;
            if (ld.load_ready !== 1'b0) begin
               $display("FAIL load_ready_low got=%b want=0", ld.load_ready);
               errors++;
            end
         end
         if (k > FRAME && k < 2 * FRAME && (k % L) == 2) begin
            checks++;
            if (seg !== want[(k / L) % N]) begin
               $display("FAIL load_digit%0d got=%b want=%b", (k / L) % N, seg, want[(k / L) % N]);
               errors++;
            end
         end
      end
      ld.load_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      int acc_k;
      bit second;
      logic [15:0] v1, v2;
      v1 = 16'($urandom);
      v2 = 16'($urandom);
      acc_k = -1;
      second = 1'b0;
      do_reset();
      for (int c = 0; c < 3 * FRAME; c++) begin
         bit take;
         if (k == 2) begin
            ld.load_valid = 1'b1;
            ld.digits_in = v1;
         end else if (k == 5) begin
            ld.load_valid = 1'b1;
            ld.digits_in = v2;
            second = 1'b1;
         end
         take = ld.load_valid && ld.load_ready;
         step();
         if (take) begin
            ld.load_valid = 1'b0;
            if (second && acc_k < 0) acc_k = k;
         end
         checks++;
         if ({frame_done, ld.load_ready, an, seg} !== expected()) begin
            $display("FAIL b2b_scan k=%0d got=%b want=%b", k, {frame_done, ld.load_ready, an, seg}, expected());
            errors++;
         end
      end
      ld.load_valid = 1'b0;
      checks++;
      if (acc_k != FRAME + 1) begin
         $display("FAIL b2b_accept_cycle got=%0d want=%0d", acc_k, FRAME + 1);
         errors++;
      end
      checks++;
      if (m_active !== v2) begin
         $display("FAIL b2b_final_value got=%h want=%h", m_active, v2);
         errors++;
      end
   endtask

   task automatic test_hex();
      logic [6:0] want [4] = '{7'b1000111, 7'b1001111, 7'b0011111, 7'b1110111};
      do_reset();
      for (int c = 0; c < 6 * FRAME; c++) begin
         bit take;
         if (k == 2) begin
            ld.load_valid = 1'b1;
            ld.digits_in = 16'hABEF;
         end else if (k > 2 * FRAME && !ld.load_valid && $urandom_range(0, 5) == 0) begin
            ld.load_valid = 1'b1;
            ld.digits_in = 16'($urandom);
         end
         take = ld.load_valid && ld.load_ready;
         step();
         if (take) ld.load_valid = 1'b0;
         checks++;
         if ({frame_done, ld.load_ready, an, seg} !== expected()) begin
            $display("FAIL hex_scan k=%0d got=%b want=%b", k, {frame_done, ld.load_ready, an, seg}, expected());
            errors++;
         end
         if (k > FRAME && k < 2 * FRAME && (k % L) == 2) begin
            checks++;
            if (seg !== want[(k / L) % N]) begin
               $display("FAIL hex_digit%0d got=%b want=%b", (k / L) % N, seg, want[(k / L) % N]);
               errors++;
            end
         end
      end
      ld.load_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int c = 0; c < FRAME + 15; c++) begin
         ld.load_valid = (k == 2) || (k == FRAME + 3);
         ld.digits_in = (k == 2) ? 16'h1234 : 16'h9876;
         step();
      end
      ld.load_valid = 1'b0;
      checks++;
      if (an !== 4'b0100 || ld.load_ready !== 1'b0) begin
         $display("FAIL mid_precondition an=%b ready=%b want an=0100 ready=0", an, ld.load_ready);
         errors++;
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (seg !== 7'h0 || an !== 4'h0 || ld.load_ready !== 1'b1) begin
         $display("FAIL mid_reset_blank seg=%b an=%b ready=%b want 0 0 1", seg, an, ld.load_ready);
         errors++;
      end
      @(negedge clk);
      reset = 1'b0;
      k = 0;
      m_active = 16'h0;
      m_shadow = 16'h0;
      m_pending = 1'b0;
      for (int c = 0; c < 10; c++) begin
         step();
         checks++;
         if ({frame_done, ld.load_ready, an, seg} !== expected()) begin
            $display("FAIL mid_restart k=%0d got=%b want=%b", k, {frame_done, ld.load_ready, an, seg}, expected());
            errors++;
         end
         if (k == 3) begin
            checks++;
            if (an !== 4'b0001 || seg !== 7'b1111110) begin
               $display("FAIL mid_restart_digit0 an=%b seg=%b want an=0001 seg=1111110", an, seg);
               errors++;
            end
         end
      end
   endtask

   task automatic test_leading_zero();
`ifdef LEADING_ZERO_BLANK_EN
      logic [3:0] want_an [4] = '{4'b0001, 4'b0010, 4'b0000, 4'b0000};
`else
      logic [3:0] want_an [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
`endif
      do_reset();
      for (int c = 0; c < 2 * FRAME + 2; c++) begin
         ld.load_valid = (k == 2);
         ld.digits_in = 16'h0050;
         step();
         checks++;
         if ({frame_done, ld.load_ready, an, seg} !== expected()) begin
            $display("FAIL lzb_scan k=%0d got=%b want=%b", k, {frame_done, ld.load_ready, an, seg}, expected());
            errors++;
         end
         if (k > FRAME && k < 2 * FRAME && (k % L) == 3) begin
            checks++;
            if (an !== want_an[(k / L) % N]) begin
               $display("FAIL lzb_digit%0d an=%b want=%b", (k / L) % N, an, want_an[(k / L) % N]);
               errors++;
            end
         end
      end
      ld.load_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_load();
      test_back_to_back();
      test_hex();
      test_reset_mid();
      test_leading_zero();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
